// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// producing {remainder, quotient} for HI/LO with a registered ready handshake.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_neg_quot;
    logic        r_neg_rem;
    logic [63:0] r_result;
    logic        r_ready;

    state_t      w_state_next;
    logic [5:0]  w_cnt_next;
    logic [64:0] w_work_next;
    logic [31:0] w_divisor_next;
    logic        w_neg_quot_next;
    logic        w_neg_rem_next;
    logic [63:0] w_result_next;
    logic        w_ready_next;

    logic        w_dividend_neg;
    logic        w_divisor_neg;
    logic [31:0] w_dividend_abs;
    logic [31:0] w_divisor_abs;
    logic [32:0] w_diff;
    logic [31:0] w_quot_raw;
    logic [31:0] w_rem_raw;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // Magnitudes of the live operands; 0x80000000 stays 0x80000000, read as unsigned
    assign w_dividend_neg = signed_div_i & opdata1_i[31];
    assign w_divisor_neg  = signed_div_i & opdata2_i[31];
    assign w_dividend_abs = w_dividend_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign w_divisor_abs  = w_divisor_neg  ? (32'd0 - opdata2_i) : opdata2_i;

    // Trial subtraction of the divisor from the partial remainder
    assign w_diff     = r_work[64:32] - {1'b0, r_divisor};
    assign w_quot_raw = r_work[31:0];
    assign w_rem_raw  = r_work[64:33];
    assign w_quot_fix = r_neg_quot ? (32'd0 - w_quot_raw) : w_quot_raw;
    assign w_rem_fix  = r_neg_rem  ? (32'd0 - w_rem_raw)  : w_rem_raw;

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_work_next     = r_work;
        w_divisor_next  = r_divisor;
        w_neg_quot_next = r_neg_quot;
        w_neg_rem_next  = r_neg_rem;
        w_result_next   = r_result;
        w_ready_next    = r_ready;

        case (r_state)
            S_FREE: begin
                w_result_next = 64'd0;
                w_ready_next  = 1'b0;
                if (start_i && !annul_i) begin
                    w_work_next     = {32'd0, w_dividend_abs, 1'b0};
                    w_divisor_next  = w_divisor_abs;
                    w_neg_quot_next = w_dividend_neg ^ w_divisor_neg;
                    w_neg_rem_next  = w_dividend_neg;
                    w_cnt_next      = 6'd0;
                    w_state_next    = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end

            S_BYZERO: begin
                w_result_next = 64'd0;
                w_ready_next  = 1'b1;
                w_state_next  = S_END;
            end

            S_ON: begin
                if (annul_i) begin
                    w_cnt_next    = 6'd0;
                    w_result_next = 64'd0;
                    w_ready_next  = 1'b0;
                    w_state_next  = S_FREE;
                end else if (r_cnt != 6'd32) begin
                    if (w_diff[32]) begin
                        w_work_next = {r_work[63:0], 1'b0};
                    end else begin
                        w_work_next = {w_diff[31:0], r_work[31:0], 1'b1};
                    end
                    w_cnt_next = r_cnt + 6'd1;
                end else begin
                    w_result_next = {w_rem_fix, w_quot_fix};
                    w_ready_next  = 1'b1;
                    w_state_next  = S_END;
                end
            end

            S_END: begin
                // Execute keeps start_i high until it has consumed the result
                if (!start_i) begin
                    w_result_next = 64'd0;
                    w_ready_next  = 1'b0;
                    w_state_next  = S_FREE;
                end
            end

            default: begin
                w_state_next = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= 6'd0;
            r_work     <= 65'd0;
            r_divisor  <= 32'd0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= 64'd0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_work     <= w_work_next;
            r_divisor  <= w_divisor_next;
            r_neg_quot <= w_neg_quot_next;
            r_neg_rem  <= w_neg_rem_next;
            r_result   <= w_result_next;
            r_ready    <= w_ready_next;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results are queued when a division
// is launched and popped when ready_o rises.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          n_tests;
    int          n_fail;
    logic [63:0] sb_q[$];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer division truncates toward zero, remainder takes the dividend's sign
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        la = sgn ? longint'($signed(a)) : longint'(a);
        lb = sgn ? longint'($signed(b)) : longint'(b);
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int hold);
        logic [63:0] exp;
        int          lat;
        int          want_lat;
        sb_q.push_back(exp_res);
        want_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        // Operands must be ignored once the division has been accepted
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(want_lat));
        exp = sb_q.pop_front();
        check("result", result_o, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
        $display("[TB] div sgn=%0d a=%h b=%h -> result=%h (exp %h) latency=%0d",
                 sgn, a, b, result_o, exp, lat);
    endtask

    initial begin
        int seen;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 3);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 2);
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 2);
        run_div(1'b0, 32'h1234_5678, 32'h0000_0000, 64'd0, 2);
        run_div(1'b1, 32'h8000_0001, 32'h0000_0000, 64'd0, 1);

        // Annul at iteration 10: no result, then a normal divide must still work
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        $display("[TB] annul at iteration 10, ready seen %0d times", seen);
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 2);

        // Reset at iteration 20
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset at iteration 20, ready=%0d result=%h", ready_o, result_o);

        // Reset while holding a result in END
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                seen = 1;
                break;
            end
        end
        check("end_reached", 64'(seen), 64'd1);
        check("end_result", result_o, model(1'b0, 32'd1000, 32'd9));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        $display("[TB] reset in END, ready=%0d result=%h", ready_o, result_o);

        // Overflow corner, start held through END, then immediate restart
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 40);
        run_div(1'b0, 32'd64, 32'd3, model(1'b0, 32'd64, 32'd3), 1);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 5) ? 32'($urandom_range(1, 15)) : $urandom;
            run_div(rs, ra, rb, model(rs, ra, rb), 1);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
